// File: rtl/lcd_hd44780_phy.sv
// rtl/lcd_hd44780_phy.sv - HD44780 8-bit parallel bus timing engine with init ROM.
// Define LCD_AUTOINIT_EN to leave reset in PWRUP and run the init sequence unprompted.
module lcd_hd44780_phy #(
  parameter int T_AS    = 2,
  parameter int T_PW    = 12,
  parameter int T_H     = 2,
  parameter int T_SHORT = 2100,
  parameter int T_LONG  = 82000,
  parameter int T_PWR   = 750000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA,
  input  logic [1:0] OPER,
  input  logic       ENB,
  output logic       LCD_RDY,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB
);

  localparam logic [2:0] S_PWRUP   = 3'd0;
  localparam logic [2:0] S_INIT_LD = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_SETUP   = 3'd3;
  localparam logic [2:0] S_E_HI    = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_EXEC    = 3'd6;

`ifdef LCD_AUTOINIT_EN
  localparam logic [2:0] S_RESET = S_PWRUP;
`else
  localparam logic [2:0] S_RESET = S_IDLE;
`endif

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  rom_idx_q, rom_idx_d;
  logic [1:0]  guard_q, guard_d;
  logic        rdy_q, rdy_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        init_q, init_d;
  logic        accept;
  logic        cmd_long;
  logic        cnt_done;

  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_byte = 8'h38;
      3'd1:    rom_byte = 8'h38;
      3'd2:    rom_byte = 8'h0C;
      3'd3:    rom_byte = 8'h01;
      default: rom_byte = 8'h06;
    endcase
  endfunction

  // Guard counts idle cycles so a sequencer holding ENB high gets time to present the next byte.
  assign accept   = (state_q == S_IDLE) && rdy_q && (guard_q == 2'd2) && ENB && (OPER != 2'b00);
  assign cmd_long = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
  assign cnt_done = (cnt_q == 20'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_done ? 20'd0 : cnt_q - 20'd1;
    rom_idx_d = rom_idx_q;
    rs_d      = rs_q;
    data_d    = data_q;
    init_d    = init_q;
    case (state_q)
      S_PWRUP: begin
        // Out of reset the counter is zero; first cycle arms it so PWRUP still lasts T_PWR.
        if (!init_q) begin
          init_d = 1'b1;
          cnt_d  = 20'(T_PWR - 2);
        end else if (cnt_done) begin
          state_d = S_INIT_LD;
        end
      end
      S_INIT_LD: begin
        data_d  = rom_byte(rom_idx_q);
        rs_d    = 1'b0;
        state_d = S_SETUP;
        cnt_d   = 20'(T_AS - 1);
      end
      S_IDLE: begin
        if (accept) begin
          if (OPER == 2'b11) begin
            state_d   = S_PWRUP;
            init_d    = 1'b1;
            rom_idx_d = 3'd0;
            cnt_d     = 20'(T_PWR - 1);
          end else begin
            data_d  = DATA;
            rs_d    = (OPER == 2'b01);
            state_d = S_SETUP;
            cnt_d   = 20'(T_AS - 1);
          end
        end
      end
      S_SETUP: if (cnt_done) begin
        state_d = S_E_HI;
        cnt_d   = 20'(T_PW - 1);
      end
      S_E_HI: if (cnt_done) begin
        state_d = S_HOLD;
        cnt_d   = 20'(T_H - 1);
      end
      S_HOLD: if (cnt_done) begin
        state_d = S_EXEC;
        cnt_d   = cmd_long ? 20'(T_LONG - 1) : 20'(T_SHORT - 1);
      end
      S_EXEC: if (cnt_done) begin
        if (init_q && (rom_idx_q != 3'd4)) begin
          rom_idx_d = rom_idx_q + 3'd1;
          state_d   = S_INIT_LD;
        end else begin
          init_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_RESET;
    endcase
    rdy_d   = (state_q == S_IDLE) && !accept;
    guard_d = !rdy_q ? 2'd0 : ((guard_q == 2'd2) ? 2'd2 : guard_q + 2'd1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_RESET;
      cnt_q     <= 20'd0;
      rom_idx_q <= 3'd0;
      guard_q   <= 2'd0;
      rdy_q     <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rom_idx_q <= rom_idx_d;
      guard_q   <= guard_d;
      rdy_q     <= rdy_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      init_q    <= init_d;
    end
  end

  assign LCD_RDY = rdy_q;
  assign LCD_RS  = rs_q;
  assign LCD_RW  = 1'b0;
  assign LCD_E   = (state_q == S_E_HI);
  assign LCD_DB  = data_q;

endmodule

// File: tb/tb_lcd_hd44780_phy.sv
// tb/tb_lcd_hd44780_phy.sv - directed self-checking bench for lcd_hd44780_phy.
module tb_lcd_hd44780_phy;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DATA = 8'h00;
  logic [1:0] OPER = 2'b00;
  logic       ENB = 1'b0;
  logic       LCD_RDY, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] LCD_DB;

  int checks = 0;
  int failures = 0;

  lcd_hd44780_phy #(
    .T_AS(2), .T_PW(4), .T_H(2), .T_SHORT(10), .T_LONG(40), .T_PWR(20)
  ) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .OPER(OPER), .ENB(ENB),
    .LCD_RDY(LCD_RDY), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DB(LCD_DB)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (LCD_RDY) break;
      tick();
    end
    tick();
    tick();
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, output int low, output int ehi,
                         output int pulses, output logic rs_e, output logic [7:0] db_e);
    logic prev_e = 1'b0;
    bit   seen_low = 1'b0;
    low = 0; ehi = 0; pulses = 0; rs_e = 1'b0; db_e = 8'h00;
    wait_idle();
    OPER = op; DATA = d; ENB = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (!LCD_RDY) begin
        low++;
        seen_low = 1'b1;
        ENB = 1'b0;
      end else if (seen_low) begin
        break;
      end
      if (LCD_E) begin
        ehi++;
        rs_e = LCD_RS;
        db_e = LCD_DB;
        if (!prev_e) pulses++;
      end
      prev_e = LCD_E;
    end
    ENB = 1'b0; OPER = 2'b00;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (LCD_E !== 1'b0) begin failures++; $display("FAIL reset_e got=%b exp=0", LCD_E); end
    checks++; if (LCD_RS !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b exp=0", LCD_RS); end
    checks++; if (LCD_RW !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", LCD_RW); end
    checks++; if (LCD_DB !== 8'h00) begin failures++; $display("FAIL reset_db got=%h exp=00", LCD_DB); end
    checks++; if (LCD_RDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", LCD_RDY); end
    tick(); tick();
    RST = 1'b0;
    tick();
`ifdef LCD_AUTOINIT_EN
    checks++; if (LCD_RDY !== 1'b0) begin failures++; $display("FAIL reset_rdy_autoinit got=%b exp=0", LCD_RDY); end
    for (int i = 0; i < 400; i++) begin
      if (LCD_RDY) break;
      tick();
    end
    checks++; if (LCD_RDY !== 1'b1) begin failures++; $display("FAIL autoinit_done got=%b exp=1", LCD_RDY); end
`else
    checks++; if (LCD_RDY !== 1'b1) begin failures++; $display("FAIL reset_rdy_release got=%b exp=1", LCD_RDY); end
`endif
  endtask

  task automatic test_char();
    int low, ehi, pulses;
    logic rs_e;
    logic [7:0] db_e;
    run_cmd(2'b01, 8'h52, low, ehi, pulses, rs_e, db_e);
    checks++; if (low !== 19) begin failures++; $display("FAIL char_busy got=%0d exp=19", low); end
    checks++; if (ehi !== 4) begin failures++; $display("FAIL char_e_width got=%0d exp=4", ehi); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL char_pulses got=%0d exp=1", pulses); end
    checks++; if (rs_e !== 1'b1) begin failures++; $display("FAIL char_rs got=%b exp=1", rs_e); end
    checks++; if (db_e !== 8'h52) begin failures++; $display("FAIL char_db got=%h exp=52", db_e); end
    checks++; if (LCD_RW !== 1'b0) begin failures++; $display("FAIL char_rw got=%b exp=0", LCD_RW); end
  endtask

  task automatic test_instr();
    logic [7:0] bytes [4] = '{8'h01, 8'h0C, 8'h03, 8'h04};
    int         exp_low [4] = '{49, 19, 49, 19};
    int low, ehi, pulses;
    logic rs_e;
    logic [7:0] db_e;
    for (int k = 0; k < 4; k++) begin
      run_cmd(2'b10, bytes[k], low, ehi, pulses, rs_e, db_e);
      checks++; if (low !== exp_low[k]) begin failures++; $display("FAIL instr_busy[%h] got=%0d exp=%0d", bytes[k], low, exp_low[k]); end
      checks++; if (rs_e !== 1'b0) begin failures++; $display("FAIL instr_rs[%h] got=%b exp=0", bytes[k], rs_e); end
      checks++; if (db_e !== bytes[k]) begin failures++; $display("FAIL instr_db got=%h exp=%h", db_e, bytes[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [9] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h4C, 8'h43, 8'h44};
    logic [7:0] got [9];
    int extra = 0;
    wait_idle();
    OPER = 2'b01; DATA = bytes[0]; ENB = 1'b1;
    for (int i = 0; i < 9; i++) begin
      got[i] = 8'hFF;
      for (int n = 0; n < 60; n++) begin
        tick();
        if (LCD_E) begin got[i] = LCD_DB; break; end
      end
      for (int n = 0; n < 100; n++) begin
        tick();
        if (LCD_RDY) break;
      end
      if (i == 8) begin
        ENB = 1'b0;
      end else begin
        tick(); tick();
        DATA = bytes[i + 1];
      end
    end
    OPER = 2'b00;
    for (int i = 0; i < 9; i++) begin
      checks++; if (got[i] !== bytes[i]) begin failures++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got[i], bytes[i]); end
    end
    for (int n = 0; n < 30; n++) begin
      tick();
      if (LCD_E) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_extra_e got=%0d exp=0", extra); end
  endtask

  task automatic test_ignore();
    int e_cnt = 0, rdy_drops = 0, pulses = 0;
    logic prev_e = 1'b0;
    logic [7:0] db_e = 8'h00;
    wait_idle();
    OPER = 2'b00; DATA = 8'h77; ENB = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!LCD_RDY) rdy_drops++;
      if (LCD_E) e_cnt++;
    end
    ENB = 1'b0;
    checks++; if (e_cnt !== 0) begin failures++; $display("FAIL ignore_nop_e got=%0d exp=0", e_cnt); end
    checks++; if (rdy_drops !== 0) begin failures++; $display("FAIL ignore_nop_rdy got=%0d exp=0", rdy_drops); end
    OPER = 2'b01; DATA = 8'h41; ENB = 1'b1;
    tick();
    ENB = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (n == 3) begin DATA = 8'h42; ENB = 1'b1; end
      if (n == 5) ENB = 1'b0;
      tick();
      if (LCD_E) begin
        db_e = LCD_DB;
        if (!prev_e) pulses++;
      end
      prev_e = LCD_E;
    end
    OPER = 2'b00;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL ignore_busy_pulses got=%0d exp=1", pulses); end
    checks++; if (db_e !== 8'h41) begin failures++; $display("FAIL ignore_busy_db got=%h exp=41", db_e); end
    checks++; if (LCD_RDY !== 1'b1) begin failures++; $display("FAIL ignore_busy_rdy got=%b exp=1", LCD_RDY); end
  endtask

  task automatic test_init();
    logic [7:0] exp_db [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    logic [7:0] db [5];
    int start [5];
    int stop [5];
    int pulses = 0, idx = -1, done_idx = -1;
    logic prev_e = 1'b0;
    for (int k = 0; k < 5; k++) begin db[k] = 8'hFF; start[k] = 0; stop[k] = 0; end
    wait_idle();
    OPER = 2'b11; ENB = 1'b1;
    for (int n = 0; n < 500; n++) begin
      tick();
      if (!LCD_RDY && idx < 0) begin idx = 0; ENB = 1'b0; end
      else if (idx >= 0) idx++;
      if (idx >= 0 && LCD_RDY) begin done_idx = idx; break; end
      if (LCD_E && !prev_e && pulses < 5) begin db[pulses] = LCD_DB; start[pulses] = idx; end
      if (!LCD_E && prev_e && pulses < 5) begin stop[pulses] = idx; pulses++; end
      prev_e = LCD_E;
    end
    ENB = 1'b0; OPER = 2'b00;
    checks++; if (pulses !== 5) begin failures++; $display("FAIL init_pulses got=%0d exp=5", pulses); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (db[k] !== exp_db[k]) begin failures++; $display("FAIL init_db[%0d] got=%h exp=%h", k, db[k], exp_db[k]); end
    end
    checks++; if (start[0] !== 23) begin failures++; $display("FAIL init_pwrup_delay got=%0d exp=23", start[0]); end
    checks++; if (start[1] - stop[0] !== 15) begin failures++; $display("FAIL init_gap_short got=%0d exp=15", start[1] - stop[0]); end
    checks++; if (start[4] - stop[3] !== 45) begin failures++; $display("FAIL init_gap_long got=%0d exp=45", start[4] - stop[3]); end
    checks++; if (done_idx - stop[4] !== 13) begin failures++; $display("FAIL init_rdy_after_last got=%0d exp=13", done_idx - stop[4]); end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    wait_idle();
    OPER = 2'b01; DATA = 8'h55; ENB = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (!LCD_RDY) ENB = 1'b0;
      if (LCD_E) begin found = 1'b1; break; end
    end
    ENB = 1'b0; OPER = 2'b00;
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL abort_e_seen got=%b exp=1", found); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (LCD_E !== 1'b0) begin failures++; $display("FAIL abort_e got=%b exp=0", LCD_E); end
    checks++; if (LCD_DB !== 8'h00) begin failures++; $display("FAIL abort_db got=%h exp=00", LCD_DB); end
    checks++; if (LCD_RS !== 1'b0) begin failures++; $display("FAIL abort_rs got=%b exp=0", LCD_RS); end
    checks++; if (LCD_RDY !== 1'b0) begin failures++; $display("FAIL abort_rdy got=%b exp=0", LCD_RDY); end
    tick();
    RST = 1'b0;
    tick();
`ifdef LCD_AUTOINIT_EN
    checks++; if (LCD_RDY !== 1'b0) begin failures++; $display("FAIL abort_restart_rdy got=%b exp=0", LCD_RDY); end
`else
    checks++; if (LCD_RDY !== 1'b1) begin failures++; $display("FAIL abort_restart_rdy got=%b exp=1", LCD_RDY); end
`endif
  endtask

  initial begin
    test_reset();
    test_char();
    test_instr();
    test_back_to_back();
    test_ignore();
    test_init();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_phy.md
LCD_HD44780_PHY -- requirements
Module: lcd_hd44780_phy

Interface
REQ-001 SHALL have clock CLK, input, 1 bit: system clock; all state changes on rising edge.
REQ-002 SHALL have reset RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have input DATA, 8 bits: character code or instruction byte from the upstream message sequencer.
REQ-004 SHALL have input OPER, 2 bits: 00 none, 01 write character, 10 write instruction, 11 re-run init sequence.
REQ-005 SHALL have input ENB, 1 bit: request level from sequencer; may stay high across consecutive commands.
REQ-006 SHALL have output LCD_RDY, 1 bit: high when idle and able to accept a command.
REQ-007 SHALL have outputs LCD_RS (1), LCD_RW (1, always 0), LCD_E (1) and LCD_DB (8): HD44780 8-bit parallel bus.
REQ-008 SHALL have parameters T_AS (default 2), T_PW (default 12), T_H (default 2), T_SHORT (default 2100), T_LONG (default 82000) and T_PWR (default 750000): cycle counts for setup, E pulse width, hold, 42 us exec, 1.64 ms exec and 15 ms power-up at 50 MHz.

Function
REQ-009 SHALL implement states PWRUP, INIT_LD, IDLE, SETUP, E_HI, HOLD and EXEC, with one shared 20-bit down-counter.
REQ-010 SHALL accept a command on a rising edge where LCD_RDY = 1, ENB = 1, OPER != 00, and LCD_RDY has been high for at least 2 preceding cycles (qualification guard).
REQ-011 SHALL capture DATA and OPER on acceptance, drive LCD_RDY low from the next cycle, and leave LCD_RDY low until EXEC completes.
REQ-012 SHALL ignore ENB while busy, with no queuing, and SHALL ignore OPER = 00 with LCD_RDY remaining high.
REQ-013 SHALL, in SETUP, drive LCD_RS = 1 for OPER 01 and 0 otherwise, drive LCD_DB = captured byte, hold LCD_E = 0, and stay for T_AS cycles.
REQ-014 SHALL, in E_HI, hold LCD_E = 1 for T_PW cycles, with RS and DB held stable.
REQ-015 SHALL, in HOLD, hold LCD_E = 0 for T_H cycles with RS and DB still held.
REQ-016 SHALL, in EXEC, wait T_LONG cycles when the byte is an instruction equal to 0x01, 0x02 or 0x03, and T_SHORT cycles for all other bytes, including characters.
REQ-017 SHALL, after EXEC, return to INIT_LD if the init sequence is in progress, otherwise to IDLE with LCD_RDY = 1 on the following cycle.
REQ-018 SHALL, for OPER = 11, run the init sequence: ROM bytes 0x38, 0x38, 0x0C, 0x01, 0x06, each as an instruction through SETUP/E_HI/HOLD/EXEC, then enter IDLE.
REQ-019 SHALL, in PWRUP, count T_PWR cycles before the first ROM byte, with LCD_E = 0 and LCD_RDY = 0.
REQ-020 SHALL use a 3-bit init ROM index that stops at 4, with no wrap.
REQ-021 SHALL keep LCD_RW = 0 in all states.
REQ-022 SHALL keep LCD_E = 0 in every state except E_HI.

Reset
REQ-023 SHALL, on RST assertion, force LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DB = 0x00, LCD_RDY = 0, counter = 0, ROM index = 0 and qualification guard = 0 immediately, without waiting for a clock edge.
REQ-024 SHALL abort any transfer cleanly when RST is asserted mid-transfer, including during E_HI; no partial strobe longer than the reset delay is permitted.
REQ-025 SHALL choose the post-reset state according to REQ-026 and REQ-027.

Configuration
REQ-026 SHALL, with macro LCD_AUTOINIT_EN defined, leave reset in PWRUP, then run the init sequence automatically; LCD_RDY first rises after the final 0x06 EXEC.
REQ-027 SHALL, without LCD_AUTOINIT_EN, leave reset in IDLE with LCD_RDY = 1 one cycle after RST deasserts; init runs only on OPER = 11, preceded by PWRUP.

Verification (sim parameters: T_AS=2, T_PW=4, T_H=2, T_SHORT=10, T_LONG=40, T_PWR=20)
REQ-028 SHALL cover: AUTOINIT on, RST release -> 20 idle cycles, then five E pulses carrying DB = 38, 38, 0C, 01, 06, a 40-cycle gap after 01, then LCD_RDY = 1.
REQ-029 SHALL cover: ENB = 1, OPER = 01, DATA = 0x52 held -> RS = 1, DB = 0x52, E high exactly 4 cycles, LCD_RDY low for 2 + 4 + 2 + 10 cycles plus the accept cycle.
REQ-030 SHALL cover: OPER = 10, DATA = 0x01 -> RS = 0 and a 40-cycle EXEC; DATA = 0x0C -> a 10-cycle EXEC.
REQ-031 SHALL cover: ENB held high across 9 characters with DATA changing 2 cycles after LCD_RDY rises -> each new byte is captured, with no stale repeat and no byte lost.
REQ-032 SHALL cover: RST pulsed while E = 1 -> LCD_E = 0 and LCD_DB = 0x00 in the same cycle, and a fresh PWRUP/IDLE per the macro.
REQ-033 SHALL cover: OPER = 00 with ENB = 1, or ENB pulsed while busy -> no E pulse and LCD_RDY unaffected.
